ase_run_ctrl: RTL and testbench

Parametrised simulation-run controller for the ASE environment. It turns the static run configuration into live behaviour: it latches mode, timeout and test count, tracks test sessions, and measures inactivity across NUM_CH monitored channels. It decides when the simulator must be killed under each ASE mode and reports the kill reason. It sits beside the DPI bridge in the ASE top level, consumes per-channel activity strobes, and drives the sim-kill request that the DPI layer acts on.

---
 rtl/ase_run_ctrl_pkg.sv | 38 +++
 rtl/ase_idle_timer.sv | 27 ++
 rtl/ase_run_ctrl.sv | 147 ++++++++++++++
 tb/tb_ase_run_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ase_run_ctrl_pkg.sv
// Shared types and constants for the ASE run controller: FSM states, kill
// reasons, ASE mode encodings and the default-width run configuration record.
package ase_run_ctrl_pkg;

  localparam int ASE_NUM_CH     = 4;
  localparam int ASE_TIMEOUT_W  = 32;
  localparam int ASE_TEST_CNT_W = 16;

  localparam logic [2:0] ASE_MODE_DAEMON          = 3'd1;
  localparam logic [2:0] ASE_MODE_TIMEOUT_SIMKILL = 3'd2;
  localparam logic [2:0] ASE_MODE_SW_SIMKILL      = 3'd3;
  localparam logic [2:0] ASE_MODE_REGRESSION      = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    KILL  = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    SW         = 2'd1,
    TIMEOUT    = 2'd2,
    REGRESSION = 2'd3
  } kill_reason_e;

  typedef struct packed {
    logic [2:0]                mode;
    logic [ASE_TIMEOUT_W-1:0]  timeout;
    logic [ASE_TEST_CNT_W-1:0] num_tests;
  } ase_run_cfg_t;

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return (mode >= ASE_MODE_DAEMON) && (mode <= ASE_MODE_REGRESSION);
  endfunction

endpackage

// File: rtl/ase_idle_timer.sv
// Saturating inactivity counter with enable, synchronous clear (which wins
// over enable) and an equality compare against a programmable limit.
module ase_idle_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] cmp_val,
  output logic [W-1:0] cnt,
  output logic         eq
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign eq = (cnt == cmp_val);

endmodule

// File: rtl/ase_run_ctrl.sv
// ASE simulation-run controller: latches the run configuration, tracks test
// sessions and channel inactivity, and raises a sticky sim-kill with a reason.
module ase_run_ctrl
  import ase_run_ctrl_pkg::*;
#(
  parameter int NUM_CH     = ASE_NUM_CH,
  parameter int TIMEOUT_W  = ASE_TIMEOUT_W,
  parameter int TEST_CNT_W = ASE_TEST_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [2:0]            cfg_mode,
  input  logic [TIMEOUT_W-1:0]  cfg_timeout,
  input  logic [TEST_CNT_W-1:0] cfg_num_tests,
  input  logic [NUM_CH-1:0]     ch_active,
  input  logic                  test_start,
  input  logic                  test_done,
  input  logic                  sw_kill_req,
  output logic                  session_ready,
  output logic                  sim_kill,
  output logic [1:0]            kill_reason,
  output logic [TEST_CNT_W-1:0] tests_done_cnt,
  output logic [TIMEOUT_W-1:0]  idle_cnt,
  output logic                  cfg_err,
  output logic [1:0]            run_state
);

  typedef struct packed {
    logic [2:0]            mode;
    logic [TIMEOUT_W-1:0]  timeout;
    logic [TEST_CNT_W-1:0] num_tests;
  } run_cfg_t;

  run_state_e            state_q, state_d;
  kill_reason_e          reason_q, reason_d, cause;
  run_cfg_t              cfg_q;
  logic [TEST_CNT_W-1:0] done_cnt_q, done_cnt_inc;
  logic                  any_active, live, done_fire, arm_to_run, enter_kill;
  logic                  idle_en, idle_clr, idle_eq;
  logic                  ready_d, sim_kill_d, cfg_err_d;
  logic                  ready_q, sim_kill_q, cfg_err_q;

  // All control inputs are single-cycle strobes sampled on the rising edge;
  // there is no backpressure, an input not acted on in the current state is dropped.
  assign any_active   = |ch_active;
  assign live         = (state_q == ARMED) || (state_q == RUN);
  assign done_fire    = (state_q == RUN) && test_done;
  assign done_cnt_inc = (done_cnt_q == '1) ? done_cnt_q : done_cnt_q + 1'b1;

  // Kill causes in priority order; regression compares the post-increment count.
  always_comb begin
    cause = NONE;
    if (live) begin
      if ((cfg_q.mode == ASE_MODE_SW_SIMKILL) && sw_kill_req) begin
        cause = SW;
      end else if ((cfg_q.mode == ASE_MODE_REGRESSION) && (cfg_q.num_tests != '0) &&
                   done_fire && (done_cnt_inc == cfg_q.num_tests)) begin
        cause = REGRESSION;
      end else if ((cfg_q.mode == ASE_MODE_TIMEOUT_SIMKILL) && (cfg_q.timeout != '0) &&
                   idle_eq) begin
        cause = TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cfg_valid) state_d = ARMED;
      ARMED: begin
        if (cause != NONE)   state_d = KILL;
        else if (test_start) state_d = RUN;
      end
      RUN: begin
        if (cause != NONE)  state_d = KILL;
        else if (test_done) state_d = ARMED;
      end
      KILL:  state_d = KILL;
    endcase
  end

  assign arm_to_run = (state_q == ARMED) && (state_d == RUN);
  assign enter_kill = (state_q != KILL) && (state_d == KILL);

  always_comb begin
    ready_d    = (state_d == ARMED);
    sim_kill_d = (state_d == KILL);
    cfg_err_d  = cfg_valid && ((state_q != IDLE) || !mode_is_legal(cfg_mode));
    reason_d   = enter_kill ? cause : reason_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '{mode: ASE_MODE_DAEMON, timeout: '0, num_tests: '0};
      done_cnt_q <= '0;
      reason_q   <= NONE;
      ready_q    <= 1'b0;
      sim_kill_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && cfg_valid) begin
        cfg_q <= '{mode:      mode_is_legal(cfg_mode) ? cfg_mode : ASE_MODE_DAEMON,
                   timeout:   cfg_timeout,
                   num_tests: cfg_num_tests};
      end
      if (done_fire) begin
        done_cnt_q <= done_cnt_inc;
      end
      reason_q   <= reason_d;
      ready_q    <= ready_d;
      sim_kill_q <= sim_kill_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign idle_en  = live && !any_active;
  assign idle_clr = any_active || arm_to_run || enter_kill;

  ase_idle_timer #(
    .W (TIMEOUT_W)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (idle_en),
    .clr     (idle_clr),
    .cmp_val (cfg_q.timeout),
    .cnt     (idle_cnt),
    .eq      (idle_eq)
  );

  assign session_ready  = ready_q;
  assign sim_kill       = sim_kill_q;
  assign kill_reason    = reason_q;
  assign tests_done_cnt = done_cnt_q;
  assign cfg_err        = cfg_err_q;
  assign run_state      = state_q;

endmodule

// File: tb/tb_ase_run_ctrl.sv
// Bench for ase_run_ctrl: directed vector table, hand-written corner-case
// sequences and a randomized run against a behavioural reference model.
module tb_ase_run_ctrl;

  localparam int     NUM_CH   = 4;
  localparam int     TW       = 32;
  localparam int     CW       = 16;
  localparam longint IDLE_MAX = (64'sd1 <<< TW) - 1;
  localparam longint CNT_MAX  = (64'sd1 <<< CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [2:0]        cfg_mode = '0;
  logic [TW-1:0]     cfg_timeout = '0;
  logic [CW-1:0]     cfg_num_tests = '0;
  logic [NUM_CH-1:0] ch_active = '0;
  logic              test_start = 1'b0;
  logic              test_done = 1'b0;
  logic              sw_kill_req = 1'b0;
  logic              session_ready, sim_kill, cfg_err;
  logic [1:0]        kill_reason, run_state;
  logic [CW-1:0]     tests_done_cnt;
  logic [TW-1:0]     idle_cnt;

  always #5 clk = ~clk;

  ase_run_ctrl #(
    .NUM_CH     (NUM_CH),
    .TIMEOUT_W  (TW),
    .TEST_CNT_W (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_mode       (cfg_mode),
    .cfg_timeout    (cfg_timeout),
    .cfg_num_tests  (cfg_num_tests),
    .ch_active      (ch_active),
    .test_start     (test_start),
    .test_done      (test_done),
    .sw_kill_req    (sw_kill_req),
    .session_ready  (session_ready),
    .sim_kill       (sim_kill),
    .kill_reason    (kill_reason),
    .tests_done_cnt (tests_done_cnt),
    .idle_cnt       (idle_cnt),
    .cfg_err        (cfg_err),
    .run_state      (run_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0 idle, 1 armed, 2 running, 3 killed.
  int     m_state, m_mode, m_reason;
  longint m_to, m_nt, m_cnt, m_idle;
  bit     m_err;

  task automatic model_reset();
    m_state = 0; m_mode = 1; m_reason = 0;
    m_to = 0; m_nt = 0; m_cnt = 0; m_idle = 0; m_err = 0;
  endtask

  task automatic model_step();
    int     ns, why;
    longint new_cnt;
    bit     live, done_now, legal;
    ns       = m_state;
    why      = 0;
    live     = (m_state == 1) || (m_state == 2);
    done_now = (m_state == 2) && test_done;
    new_cnt  = (done_now && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    legal    = (cfg_mode >= 3'd1) && (cfg_mode <= 3'd4);
    m_err    = cfg_valid && (m_state != 0 || !legal);
    if (live) begin
      if (m_mode == 3 && sw_kill_req) why = 1;
      else if (m_mode == 4 && m_nt != 0 && done_now && new_cnt == m_nt) why = 3;
      else if (m_mode == 2 && m_to != 0 && m_idle == m_to) why = 2;
    end
    if (m_state == 0 && cfg_valid) begin
      ns = 1;
      m_mode = legal ? int'(cfg_mode) : 1;
      m_to = longint'(cfg_timeout);
      m_nt = longint'(cfg_num_tests);
    end else if (why != 0) begin
      ns = 3;
      m_reason = why;
    end else if (m_state == 1 && test_start) ns = 2;
    else if (m_state == 2 && test_done) ns = 1;
    if (ch_active != 0 || (m_state == 1 && ns == 2) || (live && ns == 3)) m_idle = 0;
    else if (live && m_idle < IDLE_MAX) m_idle = m_idle + 1;
    m_cnt   = new_cnt;
    m_state = ns;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input int st, input int rsn,
                           input longint cnt, input longint idle, input int err);
    chk({tag, " run_state"},      64'(run_state),      64'(st));
    chk({tag, " session_ready"},  64'(session_ready),  64'(st == 1));
    chk({tag, " sim_kill"},       64'(sim_kill),       64'(st == 3));
    chk({tag, " kill_reason"},    64'(kill_reason),    64'(rsn));
    chk({tag, " tests_done_cnt"}, 64'(tests_done_cnt), 64'(cnt));
    chk({tag, " idle_cnt"},       64'(idle_cnt),       64'(idle));
    chk({tag, " cfg_err"},        64'(cfg_err),        64'(err));
  endtask

  task automatic clear_inputs();
    cfg_valid = 0; cfg_mode = '0; cfg_timeout = '0; cfg_num_tests = '0;
    ch_active = '0; test_start = 0; test_done = 0; sw_kill_req = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; reset is released on the falling edge.
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic cfg(input int mode, input longint to, input longint nt);
    cfg_valid = 1; cfg_mode = 3'(mode); cfg_timeout = TW'(to); cfg_num_tests = CW'(nt);
    tick();
    cfg_valid = 0; cfg_mode = '0; cfg_timeout = '0; cfg_num_tests = '0;
  endtask

  typedef struct {
    bit cv; int mode; int to; int nt; int ch; bit st; bit dn; bit sw;
    int e_state; int e_reason; int e_cnt; int e_idle; int e_err;
  } vec_t;

  function automatic vec_t mk(bit cv, int mode, int to, int nt, int ch, bit st, bit dn,
                              bit sw, int es, int er, int ec, int ei, int ee);
    vec_t v;
    v.cv = cv; v.mode = mode; v.to = to; v.nt = nt; v.ch = ch;
    v.st = st; v.dn = dn; v.sw = sw;
    v.e_state = es; v.e_reason = er; v.e_cnt = ec; v.e_idle = ei; v.e_err = ee;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[16];
    bit   kill_seen;

    // Timeout scenario, one record per clock edge.
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 2, 5, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 2, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 3, 0);
    vecs[6]  = mk(0, 0, 0, 0, 4, 0, 0, 0,  2, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 2, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 3, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 4, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 5, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,  3, 2, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,  3, 2, 0, 0, 0);
    vecs[14] = mk(1, 1, 9, 0, 0, 0, 0, 0,  3, 2, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,  3, 2, 0, 0, 0);

    model_reset();
    #2;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      cfg_valid = vecs[i].cv; cfg_mode = 3'(vecs[i].mode);
      cfg_timeout = TW'(vecs[i].to); cfg_num_tests = CW'(vecs[i].nt);
      ch_active = NUM_CH'(vecs[i].ch); test_start = vecs[i].st;
      test_done = vecs[i].dn; sw_kill_req = vecs[i].sw;
      tick();
      clear_inputs();
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_reason,
                vecs[i].e_cnt, vecs[i].e_idle, vecs[i].e_err);
    end

    // Regression kill on the third completed session.
    do_reset();
    cfg(4, 0, 3);
    for (int i = 1; i <= 3; i++) begin
      test_start = 1; tick(); test_start = 0;
      test_done = 1; tick(); test_done = 0;
      if (i < 3) check_all($sformatf("regr_done%0d", i), 1, 0, i, 1, 0);
      else check_all("regr_final", 3, 3, 3, 0, 0);
    end

    // Unlimited regression never kills.
    do_reset();
    cfg(4, 0, 0);
    for (int i = 0; i < 10; i++) begin
      test_start = 1; tick(); test_start = 0;
      test_done = 1; tick(); test_done = 0;
    end
    check_all("regr_unlim", 1, 0, 10, 1, 0);

    // Software kill with one-cycle latency.
    do_reset();
    cfg(3, 0, 0);
    test_start = 1; tick(); test_start = 0;
    check_all("sw_run", 2, 0, 0, 0, 0);
    sw_kill_req = 1; tick(); sw_kill_req = 0;
    check_all("sw_kill", 3, 1, 0, 0, 0);

    // Async reset while killed, then a fresh config is accepted.
    #2;
    rst_n = 0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    model_reset();
    #1;
    rst_n = 1;
    cfg(2, 7, 0);
    check_all("post_rst_cfg", 1, 0, 0, 0, 0);

    // Daemon mode ignores software kill requests.
    do_reset();
    cfg(1, 0, 0);
    sw_kill_req = 1;
    repeat (5) tick();
    sw_kill_req = 0;
    check_all("daemon_sw", 1, 0, 0, 5, 0);

    // Illegal mode latches as daemon.
    do_reset();
    cfg(6, 3, 0);
    check_all("mode6", 1, 0, 0, 0, 1);
    test_start = 1; tick(); test_start = 0;
    check_all("mode6_run", 2, 0, 0, 0, 0);
    sw_kill_req = 1;
    repeat (10) tick();
    sw_kill_req = 0;
    check_all("mode6_daemon", 2, 0, 0, 10, 0);

    // Config during RUN is rejected and the old timeout still applies.
    do_reset();
    cfg(2, 4, 0);
    test_start = 1; tick(); test_start = 0;
    cfg(2, 100, 0);
    check_all("cfg_in_run", 2, 0, 0, 1, 1);
    repeat (3) tick();
    check_all("cfg_kept", 2, 0, 0, 4, 0);
    tick();
    check_all("cfg_kept_kill", 3, 2, 0, 0, 0);

    // Start and done together in RUN: done wins.
    do_reset();
    cfg(1, 0, 0);
    test_start = 1; tick();
    test_done = 1; tick();
    test_start = 0; test_done = 0;
    check_all("start_done", 1, 0, 1, 1, 0);
    tick();
    check_all("start_done_hold", 1, 0, 1, 2, 0);

    // Zero timeout never fires.
    do_reset();
    cfg(2, 0, 0);
    test_start = 1; tick(); test_start = 0;
    kill_seen = 0;
    repeat (1000) begin
      tick();
      if (sim_kill) kill_seen = 1;
    end
    chk("to0_no_kill", 64'(kill_seen), 64'd0);
    check_all("to0", 2, 0, 0, 1000, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cfg_valid     = (m_state == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      cfg_mode      = 3'($urandom_range(0, 7));
      cfg_timeout   = TW'($urandom_range(0, 6));
      cfg_num_tests = CW'($urandom_range(0, 3));
      ch_active     = ($urandom_range(0, 5) == 0) ? NUM_CH'($urandom_range(1, 15)) : '0;
      test_start    = ($urandom_range(0, 3) == 0);
      test_done     = ($urandom_range(0, 4) == 0);
      sw_kill_req   = ($urandom_range(0, 19) == 0);
      tick();
      check_all($sformatf("rand%0d", i), m_state, m_reason, m_cnt, m_idle, int'(m_err));
      if (m_state == 3 && $urandom_range(0, 7) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
